fp_normalize_round: RTL

- Stage directly downstream of the add/sub block adder in the single-precision FP adder datapath.
- Takes the raw 28-bit magnitude sum, carry-out, result sign and the aligned (larger) biased exponent.
- Normalises with an iterative one-bit-per-cycle left shifter, rounds to nearest-even, and packs an IEEE-754 binary32 result with status flags.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fp_normalize_round_if.sv | 36 +++
 rtl/fp_normalize_round.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fp_normalize_round_if.sv
// fp_normalize_round_if
//   Handshake bundle between the FP adder's add/sub block and the
//   normalise/round stage, plus the packed result going downstream.
//   master : upstream/downstream side (drives operands and out_ready)
//   slave  : the fp_normalize_round stage
//   Signals: in_valid/in_ready, S (magnitude), Co (carry-out), SO (sign),
//            E_in (biased exponent), out_valid/out_ready, out_data,
//            inexact/overflow/underflow status flags.
interface fp_normalize_round_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int SUM_W  = 28
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SUM_W-1:0]        S;
    logic                    Co;
    logic                    SO;
    logic [EXP_W-1:0]        E_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_data;
    logic                    inexact;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output in_valid, S, Co, SO, E_in, out_ready,
        input  in_ready, out_valid, out_data, inexact, overflow, underflow
    );

    modport slave (
        input  in_valid, S, Co, SO, E_in, out_ready,
        output in_ready, out_valid, out_data, inexact, overflow, underflow
    );
endinterface

// File: rtl/fp_normalize_round.sv
// fp_normalize_round
//   Normalise + round-to-nearest-even + pack stage of the binary32 adder.
//   The 29-bit magnitude {Co,S} is right-aligned by at most two places,
//   then left-normalised one bit per cycle until the hidden bit is set or
//   the exponent reaches the denormal floor, then rounded and packed.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (aborts any operation)
//     bus   : fp_normalize_round_if.slave (operand/result handshakes, flags)
module fp_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int SUM_W  = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_normalize_round_if.slave   bus
);
    localparam int MW  = SUM_W + 1;          // {Co, S}
    localparam int HID = FRAC_W + 3;         // hidden-bit position in M
    localparam int EW  = EXP_W + 2;          // signed working exponent
    localparam int DW  = 1 + EXP_W + FRAC_W; // packed result width

    localparam logic signed [EW-1:0] E_ONE = EW'(1);
    localparam logic signed [EW-1:0] E_MAX = EW'((2 ** EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, SHIFT, ROUND, OUT} state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          m_q, m_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic                   sign_q, sign_d;
    logic [DW-1:0]          out_data_q, out_data_d;
    logic                   inexact_q, inexact_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    // Rounding datapath, evaluated from the current M/e; only consumed in ROUND.
    logic                   lsb, g, r, st, rnd_up, mant_carry;
    logic [FRAC_W+1:0]      mant_sum;
    logic [FRAC_W:0]        mant_rnd;
    logic signed [EW-1:0]   e_rnd;
    logic [EXP_W-1:0]       exp_field;

    assign lsb        = m_q[3];
    assign g          = m_q[2];
    assign r          = m_q[1];
    assign st         = m_q[0];
    assign rnd_up     = g & (r | st | lsb);
    assign mant_sum   = {1'b0, m_q[HID:3]} + (FRAC_W+2)'(rnd_up);
    assign mant_carry = mant_sum[FRAC_W+1];
    // A carry out of the mantissa leaves exactly 1.000..0; renormalise by one.
    assign mant_rnd   = mant_carry ? {1'b1, {FRAC_W{1'b0}}} : mant_sum[FRAC_W:0];
    assign e_rnd      = e_q + EW'(mant_carry);
    // Denormals that round up into the hidden bit pick up exponent 1 here
    // because e is already pinned at 1 for them.
    assign exp_field  = mant_rnd[FRAC_W] ? e_rnd[EXP_W-1:0] : '0;

    // NOTE: every always_comb target gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        e_d         = e_q;
        sign_d      = sign_q;
        out_data_d  = out_data_q;
        inexact_d   = inexact_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d     = {bus.Co, bus.S};
                    e_d     = (bus.E_in == '0) ? E_ONE : EW'(bus.E_in);
                    sign_d  = bus.SO;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (m_q == '0) begin
                    // Exact zero rides through ROUND, which packs +0 with
                    // clear flags once sign and exponent are cleared.
                    sign_d  = 1'b0;
                    e_d     = '0;
                    state_d = ROUND;
                end else if (m_q[MW-1]) begin
                    m_d     = {2'b00, m_q[MW-1:3], |m_q[2:0]};
                    e_d     = e_q + EW'(2);
                    state_d = SHIFT;
                end else if (m_q[MW-2]) begin
                    m_d     = {1'b0, m_q[MW-1:2], |m_q[1:0]};
                    e_d     = e_q + EW'(1);
                    state_d = SHIFT;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (m_q[HID] || (e_q <= E_ONE)) begin
                    state_d = ROUND;
                end else begin
                    m_d = {m_q[MW-2:0], 1'b0};
                    e_d = e_q - E_ONE;
                end
            end
            ROUND: begin
                inexact_d = g | r | st;
                if (e_rnd >= E_MAX) begin
                    out_data_d  = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                end else begin
                    out_data_d  = {sign_q, exp_field, mant_rnd[FRAC_W-1:0]};
                    overflow_d  = 1'b0;
                    underflow_d = (g | r | st) && (exp_field == '0);
                end
                e_d     = e_rnd;
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            out_data_q  <= '0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            e_q         <= e_d;
            sign_q      <= sign_d;
            out_data_q  <= out_data_d;
            inexact_q   <= inexact_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Both handshake outputs decode straight from the state register.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.inexact   = inexact_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
